// File: rtl/sync_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sync_fifo_ctrl
// Single-clock FIFO pointer/flag controller for an external dual-port RAM.
// Keeps binary read/write pointers with a lap bit, an occupancy count, and
// registered full/empty/almost flags plus overflow/underflow reporting.
//
// Optional feature macro: FIFO_ERR_STICKY_EN
//   defined   -> overflow/underflow hold until err_clr, clr or reset
//   undefined -> overflow/underflow are one-cycle registered pulses
//
// Parameters:
//   ADDR_W   - address width, DEPTH = 2**ADDR_W
//   AF_LEVEL - almost_full when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL - almost_empty when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports:
//   clk, rst_n     - clock (rising edge), async active-low reset
//   clr            - synchronous clear, beats wr_en/rd_en
//   wr_en, rd_en   - producer / consumer requests
//   err_clr        - clears sticky error flags (sticky build only)
//   wr_ack, rd_ack - accepted ops, double as RAM write/read enables
//   waddr, raddr   - RAM addresses
//   count          - occupancy 0..DEPTH
//   full, empty, almost_full, almost_empty - registered status flags
//   overflow, underflow - write while full / read while empty
// ---------------------------------------------------------------------------
module sync_fifo_ctrl #(
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              err_clr,
  output logic              wr_ack,
  output logic              rd_ack,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

  // Reject threshold settings that could never or always fire.
  generate
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("sync_fifo_ctrl: AF_LEVEL out of range 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_ctrl: AE_LEVEL out of range 0..DEPTH-1");
    end
  endgenerate

  logic [ADDR_W:0] wptr;
  logic [ADDR_W:0] rptr;
  logic [ADDR_W:0] count_q;
  logic [ADDR_W:0] count_next;
  logic            full_q;
  logic            empty_q;
  logic            af_q;
  logic            ae_q;
  logic            ovf_q;
  logic            udf_q;
  logic            ovf_next;
  logic            udf_next;

  // Acceptance looks only at registered flags, so a simultaneous read never
  // makes room for a write in the same cycle (and vice versa).
  assign wr_ack = wr_en & ~full_q  & ~clr;
  assign rd_ack = rd_en & ~empty_q & ~clr;

  assign count_next = count_q + {{ADDR_W{1'b0}}, wr_ack}
                              - {{ADDR_W{1'b0}}, rd_ack};

  // Error flag next-state: sticky or single-cycle pulse depending on build.
  always_comb begin
    ovf_next = 1'b0;
    udf_next = 1'b0;
`ifdef FIFO_ERR_STICKY_EN
    // A new event in the err_clr cycle keeps the flag set.
    ovf_next = (wr_en & full_q)  | (ovf_q & ~err_clr);
    udf_next = (rd_en & empty_q) | (udf_q & ~err_clr);
`else
    ovf_next = wr_en & full_q;
    udf_next = rd_en & empty_q;
`endif
  end

`ifndef FIFO_ERR_STICKY_EN
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
`endif

  // Pointer, count and flag registers. clr restores the reset state; the
  // lap bit in each pointer is carried along but only the low bits leave.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else if (clr) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr    <= wptr + {{ADDR_W{1'b0}}, wr_ack};
      rptr    <= rptr + {{ADDR_W{1'b0}}, rd_ack};
      count_q <= count_next;
      full_q  <= (count_next == DEPTH_C);
      empty_q <= (count_next == '0);
      af_q    <= (count_next >= AF_C);
      ae_q    <= (count_next <= AE_C);
      ovf_q   <= ovf_next;
      udf_q   <= udf_next;
    end
  end

  assign waddr        = wptr[ADDR_W-1:0];
  assign raddr        = rptr[ADDR_W-1:0];
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_ctrl
// Directed self-checking bench for sync_fifo_ctrl (ADDR_W=4, AF=12, AE=4).
// A small behavioural model tracks pointers, count and error flags; the
// addresses written are queued and popped on each accepted read to check
// that reads follow writes in order.
// ---------------------------------------------------------------------------
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic       wr_ack;
  logic       rd_ack;
  logic [3:0] waddr;
  logic [3:0] raddr;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [4:0] m_wptr;
  logic [4:0] m_rptr;
  int         m_count;
  logic       m_ovf;
  logic       m_udf;
  logic [3:0] addr_q[$];

  sync_fifo_ctrl #(.ADDR_W(4), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .rd_en(rd_en),
    .err_clr(err_clr), .wr_ack(wr_ack), .rd_ack(rd_ack), .waddr(waddr),
    .raddr(raddr), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_wptr  = '0;
    m_rptr  = '0;
    m_count = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    addr_q.delete();
  endtask

  // Registered outputs against the model
  task automatic checkOutput(input string step);
    logic [4:0] wp;
    logic [4:0] rp;
    wp = m_wptr;
    rp = m_rptr;
    check({step, ".count"},        count,        m_count);
    check({step, ".full"},         full,         m_count == 16);
    check({step, ".empty"},        empty,        m_count == 0);
    check({step, ".almost_full"},  almost_full,  m_count >= 12);
    check({step, ".almost_empty"}, almost_empty, m_count <= 4);
    check({step, ".waddr"},        waddr,        wp[3:0]);
    check({step, ".raddr"},        raddr,        rp[3:0]);
    check({step, ".overflow"},     overflow,     m_ovf);
    check({step, ".underflow"},    underflow,    m_udf);
  endtask

  // One clock of stimulus: drive at negedge, check acks before the edge,
  // advance the model on the edge, check registered outputs after it.
  task automatic applyStimulus(input string step, input logic wr, input logic rd,
                               input logic cl, input logic ec);
    logic e_wack;
    logic e_rack;
    logic was_full;
    logic was_empty;
    logic [3:0] exp_addr;
    logic [4:0] wp;
    @(negedge clk);
    wr_en = wr; rd_en = rd; clr = cl; err_clr = ec;
    #1;
    was_full  = (m_count == 16);
    was_empty = (m_count == 0);
    e_wack = wr & ~was_full & ~cl;
    e_rack = rd & ~was_empty & ~cl;
    check({step, ".wr_ack"}, wr_ack, e_wack);
    check({step, ".rd_ack"}, rd_ack, e_rack);
    if (e_rack) begin
      if (addr_q.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL %s.scoreboard: observed empty queue expected entry", step);
      end else begin
        exp_addr = addr_q.pop_front();
        check({step, ".rd_order"}, raddr, exp_addr);
      end
    end
    if (e_wack) begin
      wp = m_wptr;
      addr_q.push_back(wp[3:0]);
    end
    @(posedge clk);
    if (cl) begin
      modelReset();
    end else begin
      if (e_wack) m_wptr = m_wptr + 5'd1;
      if (e_rack) m_rptr = m_rptr + 5'd1;
      m_count = m_count + int'(e_wack) - int'(e_rack);
`ifdef FIFO_ERR_STICKY_EN
      m_ovf = (wr & was_full)  | (m_ovf & ~ec);
      m_udf = (rd & was_empty) | (m_udf & ~ec);
`else
      m_ovf = wr & was_full;
      m_udf = rd & was_empty;
`endif
    end
    #1;
    checkOutput(step);
  endtask

  initial begin
    modelReset();
    $display("[TB] reset");
    #12;
    checkOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] fill to full");
    for (int i = 0; i < 16; i++) applyStimulus("fill", 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("wr_full",    1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("wr_full_ec", 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus("err_clr",    1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("idle1",      1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] full with both requests, then drain");
    applyStimulus("full_both", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus("drain", 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("rd_empty",  1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("idle2",     1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("err_clr2",  1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("empty_both", 1'b1, 1'b1, 1'b0, 1'b0);

    $display("[TB] streaming");
    for (int i = 0; i < 40; i++) applyStimulus("stream", 1'b1, 1'b1, 1'b0, 1'b0);

    $display("[TB] async reset mid-stream");
    for (int i = 0; i < 9; i++) applyStimulus("fill10", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] synchronous clear");
    for (int i = 0; i < 10; i++) applyStimulus("refill", 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("clr",       1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus("after_clr", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
